mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and owns the HI/LO register pair that the decoder's ToLH and LHToReg signals refer to. It is parametrised in operand width and adds the busy/done handshake, MTHI/MTLO writes, pipeline abort and divide-by-zero reporting. It sits beside the ALU in the execute stage. The pipeline stalls on `busy` before issuing MFHI/MFLO or another MDU op.

## Interface
- WIDTH, 32: operand and HI/LO width; legal values are 2 or more.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  rs operand (multiplicand or dividend).
- b  in  WIDTH  rt operand (multiplier or divisor).
- abort  in  1  pipeline flush; kills an in-flight operation.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in flight (registered).
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  pulses with `done` when a divide had b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- State machine has three states: IDLE, RUN, FIX. Iteration counter is $clog2(WIDTH) bits wide.
- IDLE:
  - If start=1, latch op, |a|, |b| and the operand sign bits. Sign bits are taken only for the signed ops; magnitudes are in WIDTH-bit unsigned form.
  - Load counter = WIDTH-1 and go to RUN.
  - When start is accepted, hi_we/lo_we in the same cycle are ignored.
  - Otherwise, hi_we loads hi<=wdata and lo_we loads lo<=wdata. Both may assert together.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - At counter == 0, go to FIX; otherwise decrement the counter.
- FIX:
  - Apply the sign correction.
  - MULT: negate the 2·WIDTH product if the operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write hi = product[2W-1:W] or remainder, and lo = product[W-1:0] or quotient.
  - Pulse done and return to IDLE.
- Divide by zero (b == 0, DIV or DIVU): the result is hi = a (raw operand) and lo = all ones. Sign fix-up is bypassed. div_by_zero=1 together with done.
- DIV of most-negative / −1: lo = 100…0, hi = 0. This is the natural wrap of the magnitude algorithm; no flag is raised.
- abort in RUN or FIX: go to IDLE at the next edge. hi/lo are unchanged, and done and div_by_zero stay 0. abort in IDLE has no effect and does not block start.
- start, hi_we and lo_we while busy are ignored; there is no queueing.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, busy 0, done 0, div_by_zero 0, hi 0, lo 0, internal accumulators 0.
- Reset is asynchronous. Asserting rst_n mid-operation drops every output to its reset value immediately; the in-flight result is lost.
- Edge e0 accepts start. RUN covers edges e1…eWIDTH. The FIX edge is eWIDTH+1.
  - busy is high for WIDTH+1 cycles, from after e0 until eWIDTH+1.
  - hi/lo/done are valid in the cycle after eWIDTH+1. For WIDTH=32, that is 34 edges after acceptance.
- done and div_by_zero are high for exactly one cycle.
- A new start in the done cycle is accepted, which gives back-to-back throughput of WIDTH+2 cycles per op.
- MTHI/MTLO latency is one cycle.
- The result register write and done are simultaneous; no partial HI/LO update is ever visible.

## Structure
- `mdu_pkg` holds the op encoding typedef (MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV) and the state enum (IDLE, RUN, FIX). The decoder imports the same op encoding.
- Single module; no sub-module is needed. The datapath (accumulator, shift/subtract, negators) and the FSM share one file.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after start; busy high 33 cycles.
- MULT −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV −7 ÷ 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7 ÷ 0 → hi=0x00000007, lo=0xFFFFFFFF, div_by_zero=1 with done. DIV 0x80000000 ÷ 0xFFFFFFFF → lo=0x80000000, hi=0, no flag.
- Abort and ignored requests, starting from hi=0x1234:
  - start at iteration 5 is ignored.
  - abort at iteration 10 → no done, hi stays 0x1234.
  - Then MTLO 0xABCD in IDLE → lo=0xABCD one cycle later.
- Start accepted in the same cycle as a previous done → second result correct with no lost cycle. start+hi_we in the same IDLE cycle → hi_we ignored.
- rst_n low at iteration 20 → busy/done/hi/lo are 0 before the next edge. After release, an idle start proceeds normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU op encoding and sequencer state for the decoder and mdu_seq.
package mdu_pkg;
    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;
endpackage

// File: rtl/mdu_seq.sv
// mdu_seq: iterative radix-2 multiply/divide unit owning the HI/LO pair.
// Works on magnitudes for WIDTH cycles, then applies sign fix-up and writes HI/LO atomically.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mb_q, mb_d, hi_q, hi_d, lo_q, lo_d;
    logic               sa_q, sa_d, sb_q, sb_d, done_q, done_d, dz_q, dz_d;
    logic               sa_in, sb_in, is_div, b_zero;
    logic [WIDTH:0]     msum, dtrial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem, quo;

    always_comb begin
        sa_in  = op[0] & a[WIDTH-1];
        sb_in  = op[0] & b[WIDTH-1];
        is_div = op_q[1];
        b_zero = (mb_q == '0);
        msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
        dtrial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mb_q};
        prod   = (sa_q ^ sb_q) ? -acc_q : acc_q;
        // Remainder follows the dividend sign; with b == 0 this restores the raw dividend.
        rem    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        quo    = b_zero ? '1 : ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mb_d    = mb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = mdu_op_e'(op);
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    acc_d   = {{WIDTH{1'b0}}, (sa_in ? -a : a)};
                    mb_d    = sb_in ? -b : b;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = RUN;
                end else begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = is_div ? (dtrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                                    : {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                                   : {msum, acc_q[WIDTH-1:1]};
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? FIX : RUN;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    hi_d   = is_div ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d   = is_div ? quo : prod[WIDTH-1:0];
                    done_d = 1'b1;
                    dz_d   = is_div & b_zero;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= MDU_MULTU;
            cnt_q   <= '0;
            acc_q   <= '0;
            mb_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mb_q    <= mb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vectors with a scoreboard queue drained by a done-triggered monitor.
module tb_mdu_seq;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;
    int          edges, bc;
    exp_t        sb_q[$];

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (div_by_zero && !done) check("dz_without_done", {31'd0, done}, 32'd1);
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_hi", hi, e.hi);
                check("result_lo", lo, e.lo);
                check("result_dz", {31'd0, div_by_zero}, {31'd0, e.dz});
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input logic hw, output int ne, output int nb);
        logic [31:0] h0;
        h0 = hi;
        sb_q.push_back('{eh, el, edz});
        op = o; a = x; b = y; start = 1'b1; hi_we = hw; wdata = 32'h5555;
        ne = 0; nb = 0;
        @(posedge clk); ne++;
        @(negedge clk); start = 1'b0; hi_we = 1'b0;
        if (hw) check("hi_we_with_start", hi, h0);
        if (busy) nb++;
        while (!done && ne < 100) begin
            @(posedge clk); ne++;
            @(negedge clk);
            if (busy) nb++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, edges, bc);
        check("multu_latency", edges, 34);
        check("multu_busy_cycles", bc, 33);
        @(negedge clk);
        run_op(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, edges, bc);
        @(negedge clk);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, edges, bc);
        @(negedge clk);
        run_op(2'b10, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 1'b1, 1'b0, edges, bc);
        @(negedge clk);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, edges, bc);
        @(negedge clk);

        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); hi_we = 1'b0;
        check("mthi", hi, 32'h1234);
        op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk); start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_hi_kept", hi, 32'h1234);
        lo_we = 1'b1; wdata = 32'hABCD;
        @(negedge clk); lo_we = 1'b0;
        check("mtlo", lo, 32'hABCD);

        run_op(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, edges, bc);
        run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, edges, bc);
        check("back_to_back_latency", edges, 34);
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 1'b1, edges, bc);
        @(negedge clk);

        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, edges, bc);
        check("post_reset_latency", edges, 34);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
